// File: rtl/demux2_buf.sv
// demux2_buf: one valid/ready stream steered by s_sel into two FIFOs.
// Each channel drains independently; back-pressure on one never stalls the other.
module demux2_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + AW'(1);
    if (pop_i)  rptr_d = rptr_q + AW'(1);
    if (push_i && !pop_i)
      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !push_i)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (reset_n && push_i)
      mem_q[wptr_q] <= wdata_i;
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

module demux2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_sel,
  output logic             m0_valid,
  input  logic             m0_ready,
  output logic [WIDTH-1:0] m0_data,
  output logic             m1_valid,
  input  logic             m1_ready,
  output logic [WIDTH-1:0] m1_data,
  output logic [CW-1:0]    count0,
  output logic [CW-1:0]    count1
);

  logic full0, full1;
  logic push0, push1;
  logic pop0, pop1;

  // Ready depends only on the selected channel's registered fullness.
  assign s_ready = s_sel ? !full1 : !full0;
  assign push0   = s_valid && s_ready && !s_sel;
  assign push1   = s_valid && s_ready &&  s_sel;
  assign pop0    = m0_valid && m0_ready;
  assign pop1    = m1_valid && m1_ready;

  demux2_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ch0 (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push0),
    .wdata_i (s_data),
    .pop_i   (pop0),
    .full_o  (full0),
    .valid_o (m0_valid),
    .data_o  (m0_data),
    .count_o (count0)
  );

  demux2_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ch1 (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push1),
    .wdata_i (s_data),
    .pop_i   (pop1),
    .full_o  (full1),
    .valid_o (m1_valid),
    .data_o  (m1_data),
    .count_o (count1)
  );

endmodule

// File: tb/tb_demux2_buf.sv
// tb_demux2_buf: directed plus random stimulus against two reference queues.
// Outputs are sampled 1ns after inputs change, well away from the clock edge.
module tb_demux2_buf;

  localparam int W  = 32;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_sel;
  logic          m0_valid;
  logic          m0_ready;
  logic [W-1:0]  m0_data;
  logic          m1_valid;
  logic          m1_ready;
  logic [W-1:0]  m1_data;
  logic [CW-1:0] count0;
  logic [CW-1:0] count1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  always #5 clk = ~clk;

  demux2_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sel    (s_sel),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_data  (m0_data),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_data  (m1_data),
    .count0   (count0),
    .count1   (count1)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the queues, then advance both.
  task automatic step(input bit rst_n, input bit v, input bit sel,
                      input logic [W-1:0] d, input bit r0, input bit r1,
                      input bit en);
    bit rdy, acc, p0, p1;
    reset_n  = rst_n;
    s_valid  = v;
    s_sel    = sel;
    s_data   = d;
    m0_ready = r0;
    m1_ready = r1;
    #1;
    rdy = sel ? (q1.size() < D) : (q0.size() < D);
    if (en) begin
      chk("s_ready", W'(s_ready), W'(rdy));
      chk("m0_valid", W'(m0_valid), W'(q0.size() != 0));
      chk("m1_valid", W'(m1_valid), W'(q1.size() != 0));
      chk("count0", W'(count0), W'(q0.size()));
      chk("count1", W'(count1), W'(q1.size()));
      if (q0.size() != 0) chk("m0_data", m0_data, q0[0]);
      if (q1.size() != 0) chk("m1_data", m1_data, q1[0]);
    end
    acc = v && rdy;
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    @(posedge clk);
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    s_valid  = 1'b1;
    s_sel    = 1'b0;
    s_data   = 32'hDEAD;
    m0_ready = 1'b0;
    m1_ready = 1'b0;

    step(0, 1, 0, 32'hDEAD, 0, 0, 0);
    step(0, 1, 1, 32'hBEEF, 0, 0, 0);

    step(1, 1, 0, 32'hA0, 0, 0, 1);
    step(1, 1, 1, 32'hB1, 0, 0, 1);
    step(1, 0, 0, 32'h0, 0, 0, 1);
    step(1, 0, 0, 32'h0, 1, 1, 1);

    step(1, 1, 0, 32'h1, 0, 0, 1);
    step(1, 1, 0, 32'h2, 0, 0, 1);
    step(1, 1, 0, 32'h99, 0, 0, 1);
    step(1, 1, 1, 32'h3, 0, 0, 1);
    step(1, 1, 0, 32'h4, 1, 1, 1);
    step(1, 1, 0, 32'h4, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 32'h0, 1, 1, 1);

    for (int i = 0; i < 10; i++)
      step(1, 1, 1, W'(i), 0, 1, 1);
    step(1, 0, 1, 32'h0, 0, 1, 1);
    step(1, 0, 1, 32'h0, 0, 1, 1);

    step(1, 1, 0, 32'hC0, 0, 0, 1);
    step(1, 1, 1, 32'hC1, 0, 0, 1);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    step(1, 1, 0, 32'h55, 0, 0, 1);
    step(1, 0, 0, 32'h0, 1, 0, 1);
    step(1, 0, 0, 32'h0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      bit rs;
      rs = ($urandom_range(0, 59) != 0);
      step(rs, 1'($urandom), 1'($urandom), $urandom,
           1'($urandom), 1'($urandom), 1);
    end
    step(1, 0, 0, 32'h0, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux2_buf.md
# demux2_buf

Buffered two-way stream demultiplexer with a registered valid/ready handshake on every port. A single producer stream is steered by a per-beat select bit into one of two independent FIFOs, each drained by its own consumer. It does the opposite job of the datapath 2:1 select: it fans one source out to two sinks. Each output channel keeps its beats in order, and back-pressure on one channel does not stall the other.

## Interface
- WIDTH, 32, data width of every beat
- DEPTH, 2, entries per output FIFO; must be a power of two, at least 2
- clk  input  1  sole clock; all state updates on the rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- s_valid  input  1  producer beat valid
- s_ready  output  1  block can accept the beat on s_data/s_sel
- s_data  input  WIDTH  producer beat
- s_sel  input  1  destination: 0 = channel 0, 1 = channel 1
- m0_valid  output  1  channel 0 head valid
- m0_ready  input  1  channel 0 consumer accepts
- m0_data  output  WIDTH  channel 0 head beat
- m1_valid  output  1  channel 1 head valid
- m1_ready  input  1  channel 1 consumer accepts
- m1_data  output  WIDTH  channel 1 head beat
- count0  output  $clog2(DEPTH)+1  channel 0 occupancy
- count1  output  $clog2(DEPTH)+1  channel 1 occupancy

## Operation
- Per channel i: circular buffer of DEPTH entries.
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - Occupancy counter count_i ranges 0..DEPTH.
- full_i = (count_i == DEPTH). empty_i = (count_i == 0).
- s_ready = !full[s_sel]. It is combinational in s_sel and registered state only, never in s_valid or m*_ready.
- Push: s_valid && s_ready. s_data is written at wptr[s_sel], that wptr increments, and the other channel is untouched.
- mi_valid = !empty_i. mi_data = buffer_i[rptr_i]. When empty, mi_data is don't-care and the bench must not check it.
- Pop on channel i: mi_valid && mi_ready. rptr_i increments.
- Push and pop on the same channel in the same cycle: both happen and count_i is unchanged.
- Full channel: a push is refused even if a pop happens in the same cycle. There is no pass-through when full.
- Ordering: FIFO order is guaranteed within a channel. There is no ordering relation between channels.
- s_sel may change freely while s_valid is high and s_ready is low. The producer is not required to hold s_sel.
- count_i is updated as +1 on push only, -1 on pop only, and unchanged otherwise. It never exceeds DEPTH and never underflows.
- Each channel's independence is required: full_0 must not affect acceptance of s_sel=1 beats, and vice versa.

## Timing
- Reset: when reset_n = 0 at an edge, all pointers and counts are cleared to 0.
  - Resulting outputs: m0_valid=0, m1_valid=0, count0=0, count1=0, s_ready=1.
  - Buffer contents are not cleared.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-stream discards all stored beats.
- Latency: a beat pushed at edge N is visible on mi_valid/mi_data after edge N. The earliest pop is at edge N+1.
- Throughput: one push per cycle, plus one pop per channel per cycle, sustained.
- s_ready reflects state after the previous edge. A pop at edge N frees space for a push at edge N+1, not at edge N.
- All outputs other than s_ready are purely registered-state functions and have no input-to-output combinational path.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with s_valid=1 -> counts 0, m0_valid=m1_valid=0, s_ready=1; no beat stored.
- Steering: push 0xA0 (sel 0) and 0xB1 (sel 1) on consecutive cycles with both ready=0 -> count0=1, count1=1, m0_data=0xA0, m1_data=0xB1.
- Fill/back-pressure (DEPTH=2): push 0x1, 0x2 to channel 0 with m0_ready=0.
  - Expected: count0=2 and s_ready=0 for sel=0, while s_ready=1 for sel=1.
  - A sel=1 beat 0x3 is accepted.
- Full with same-cycle pop: channel 0 full, m0_ready=1 and s_valid=1 with sel=0.
  - Expected: the pop of 0x1 occurs, the push is refused, and count0=1.
  - The push is accepted next cycle; channel 0 then drains 0x2 followed by the new beat.
- Wrap-around: stream 10 beats 0x0..0x9 to channel 1 with m1_ready=1 throughout -> output order 0x0..0x9, count1 never exceeds 1, no bubbles after first beat.
- Reset mid-operation: both channels holding beats, reset_n=0 for 1 cycle -> both valids drop the next cycle, counts 0; subsequent push 0x55 sel 0 emerges as first m0 beat.
